// File: rtl/dc_miss_ctrl.sv
// Data-cache miss controller: tag-store sweep, lookup, writeback/fill and tag update.
// Optional performance counters are enabled with the DC_PERF_CNT_EN macro.
module dc_miss_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [4:0]  ts_index,
  output logic        ts_wr_n,
  output logic [7:0]  ts_wdata,
  input  logic [7:0]  ts_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  input  logic        mem_ack
`ifdef DC_PERF_CNT_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned TS_W     = 8;
  localparam int unsigned NUM_SETS = 32;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FILL, S_TAG_UPD, S_DONE
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_sweep;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic               r_wr;
  logic               r_hit;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [IDX_W-1:0]   r_ts_index;
  logic               r_ts_wr_n;
  logic [TS_W-1:0]    r_ts_wdata;
  logic               r_mem_req;
  logic               r_mem_wr;
  logic [ADDR_W-1:0]  r_mem_addr;

  logic               w_ts_valid;
  logic               w_ts_dirty;
  logic [TAG_W-1:0]   w_ts_tag;
  logic               w_hit;
  logic               w_unused_off;

  assign w_ts_valid   = ts_rdata[7];
  assign w_ts_dirty   = ts_rdata[6];
  assign w_ts_tag     = ts_rdata[TAG_W-1:0];
  assign w_hit        = w_ts_valid && (w_ts_tag == r_tag);
  assign w_unused_off = ^req_addr[OFF_W-1:0];

  // Outputs are loaded together with the state they belong to, so each is a clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_wr         <= 1'b0;
      r_hit        <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_ts_index   <= '0;
      r_ts_wr_n    <= 1'b0;
      r_ts_wdata   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_sweep == IDX_W'(NUM_SETS - 1)) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_ts_wr_n   <= 1'b1;
            r_ts_index  <= r_idx;
          end else begin
            r_sweep    <= r_sweep + IDX_W'(1);
            r_ts_index <= r_sweep + IDX_W'(1);
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_tag       <= req_addr[ADDR_W-1:ADDR_W-TAG_W];
            r_idx       <= req_addr[OFF_W+IDX_W-1:OFF_W];
            r_wr        <= req_wr;
            r_ts_index  <= req_addr[OFF_W+IDX_W-1:OFF_W];
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) begin
            if (r_wr && !w_ts_dirty) begin
              r_state    <= S_TAG_UPD;
              r_ts_wr_n  <= 1'b0;
              r_ts_wdata <= {1'b1, r_wr, r_tag};
            end else begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_hit   <= 1'b1;
            end
          end else if (w_ts_valid && w_ts_dirty) begin
            // Victim tag is latched straight into the writeback address.
            r_state    <= S_WB;
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b1;
            r_mem_addr <= {w_ts_tag, r_idx, OFF_W'(0)};
          end else begin
            r_state    <= S_FILL;
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {r_tag, r_idx, OFF_W'(0)};
          end
        end
        S_WB: begin
          if (mem_ack) begin
            r_state    <= S_FILL;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {r_tag, r_idx, OFF_W'(0)};
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_state    <= S_TAG_UPD;
            r_mem_req  <= 1'b0;
            r_ts_wr_n  <= 1'b0;
            r_ts_wdata <= {1'b1, r_wr, r_tag};
          end
        end
        S_TAG_UPD: begin
          r_state      <= S_DONE;
          r_ts_wr_n    <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= r_hit;
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_hit   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state   <= S_INIT;
          r_sweep   <= '0;
          r_ts_wr_n <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign ts_index   = r_ts_index;
  assign ts_wr_n    = r_ts_wr_n;
  assign ts_wdata   = r_ts_wdata;
  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;

`ifdef DC_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  // Saturating counters, bumped once per completed request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_DONE) begin
      if (r_resp_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dc_miss_ctrl.sv
// Self-checking bench for dc_miss_ctrl: directed vector table, reset corner cases,
// and random requests checked against a transaction-level cache model.
module tb_dc_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr;
  logic        req_ready, resp_valid, resp_hit;
  logic [4:0]  ts_index;
  logic        ts_wr_n;
  logic [7:0]  ts_wdata, ts_rdata;
  logic        mem_req, mem_wr, mem_ack;
  logic [15:0] mem_addr;
`ifdef DC_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dc_miss_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .ts_index(ts_index), .ts_wr_n(ts_wr_n), .ts_wdata(ts_wdata), .ts_rdata(ts_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef DC_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Tag store behind the DUT, with a side port for preloading entries.
  logic [7:0] ts_mem [32];
  logic       pl_en;
  logic [4:0] pl_idx;
  logic [7:0] pl_data;
  assign ts_rdata = ts_mem[ts_index];
  always @(posedge clk) begin
    if (pl_en) ts_mem[pl_idx] <= pl_data;
    else if (!ts_wr_n) ts_mem[ts_index] <= ts_wdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        hit;
    int          lat;
    int          nph;
    logic [15:0] wb_a;
    logic [15:0] fill_a;
    int          ntw;
    logic [4:0]  tw_idx;
    logic [7:0]  tw_data;
    int          unstable;
    logic        timeout;
    logic        after_valid;
    logic        after_ready;
  } obs_t;

  // Reference model state: expected tag store and expected counters.
  logic [7:0]  ref_ts [32];
  logic [15:0] m_hit, m_miss;

  function automatic obs_t predict(input logic wr, input logic [15:0] addr, input int dly);
    obs_t p;
    logic [5:0] tag;
    logic [4:0] idx;
    logic [7:0] e;
    logic hit, wb, upd;
    tag = addr[15:10];
    idx = addr[9:5];
    e   = ref_ts[idx];
    hit = e[7] && (e[5:0] == tag);
    wb  = !hit && e[7] && e[6];
    upd = !hit || (wr && !e[6]);
    p = '{default: 0};
    p.hit    = hit;
    p.nph    = hit ? 0 : (wb ? 2 : 1);
    p.lat    = 2 + (upd ? 1 : 0) + p.nph * (dly + 1);
    p.wb_a   = wb ? {e[5:0], idx, 5'b0} : 16'h0;
    p.fill_a = hit ? 16'h0 : {tag, idx, 5'b0};
    p.ntw    = upd ? 1 : 0;
    p.tw_idx = upd ? idx : 5'd0;
    p.tw_data = upd ? {1'b1, wr, tag} : 8'h00;
    p.after_valid = 1'b0;
    p.after_ready = 1'b1;
    if (upd) ref_ts[idx] = p.tw_data;
    if (hit) begin
      if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
    end else begin
      if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    end
    return p;
  endfunction

  task automatic run_txn(input logic wr, input logic [15:0] addr, input int dly, output obs_t o);
    int g, cyc, w;
    logic inph, ph_wr;
    logic [15:0] ph_a;
    o = '{default: 0};
    g = 0;
    while (req_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (req_ready !== 1'b1) begin o.timeout = 1'b1; return; end
    req_valid = 1'b1; req_wr = wr; req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'($urandom);
    cyc = 1; inph = 1'b0; w = 0; ph_wr = 1'b0; ph_a = 16'h0;
    while (resp_valid !== 1'b1 && cyc < 200) begin
      if (!ts_wr_n) begin o.ntw++; o.tw_idx = ts_index; o.tw_data = ts_wdata; end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!inph) begin
          inph = 1'b1; w = 0; o.nph++; ph_wr = mem_wr; ph_a = mem_addr;
          if (mem_wr) o.wb_a = mem_addr; else o.fill_a = mem_addr;
        end else begin
          w++;
          if (mem_wr !== ph_wr || mem_addr !== ph_a) o.unstable++;
        end
        if (w == dly) begin mem_ack = 1'b1; inph = 1'b0; end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    if (resp_valid !== 1'b1) begin o.timeout = 1'b1; return; end
    o.hit = resp_hit;
    o.lat = cyc;
    @(negedge clk);
    o.after_valid = resp_valid;
    o.after_ready = req_ready;
  endtask

  task automatic cmp(input string nm, input obs_t o, input obs_t p, input logic [4:0] idx);
    chk({nm, ".timeout"}, 32'(o.timeout), 32'(p.timeout));
    chk({nm, ".hit"}, 32'(o.hit), 32'(p.hit));
    chk({nm, ".latency"}, 32'(o.lat), 32'(p.lat));
    chk({nm, ".mem_phases"}, 32'(o.nph), 32'(p.nph));
    chk({nm, ".wb_addr"}, 32'(o.wb_a), 32'(p.wb_a));
    chk({nm, ".fill_addr"}, 32'(o.fill_a), 32'(p.fill_a));
    chk({nm, ".mem_stable"}, 32'(o.unstable), 32'(p.unstable));
    chk({nm, ".ts_writes"}, 32'(o.ntw), 32'(p.ntw));
    chk({nm, ".ts_wr_idx"}, 32'(o.tw_idx), 32'(p.tw_idx));
    chk({nm, ".ts_wr_data"}, 32'(o.tw_data), 32'(p.tw_data));
    chk({nm, ".resp_one_cycle"}, 32'(o.after_valid), 32'(p.after_valid));
    chk({nm, ".ready_after"}, 32'(o.after_ready), 32'(p.after_ready));
    chk({nm, ".ts_entry"}, 32'(ts_mem[idx]), 32'(ref_ts[idx]));
`ifdef DC_PERF_CNT_EN
    chk({nm, ".hit_cnt"}, 32'(hit_cnt), 32'(m_hit));
    chk({nm, ".miss_cnt"}, 32'(miss_cnt), 32'(m_miss));
`endif
  endtask

  task automatic preload(input logic [4:0] idx, input logic [7:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
    ref_ts[idx] = data;
  endtask

  // Entered at a negedge with rst just released: expects the full 32-entry clear.
  task automatic sweep_check(input string nm);
    for (int i = 0; i < 32; i++) begin
      chk({nm, ".sweep_wr_n"}, 32'(ts_wr_n), 32'd0);
      chk({nm, ".sweep_idx"}, 32'(ts_index), 32'(i));
      chk({nm, ".sweep_wdata"}, 32'(ts_wdata), 32'd0);
      chk({nm, ".sweep_ready"}, 32'(req_ready), 32'd0);
      chk({nm, ".sweep_resp"}, 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk({nm, ".ready_after_sweep"}, 32'(req_ready), 32'd1);
    chk({nm, ".wr_n_after_sweep"}, 32'(ts_wr_n), 32'd1);
    for (int i = 0; i < 32; i++) ref_ts[i] = 8'h00;
    m_hit = 16'h0; m_miss = 16'h0;
  endtask

  task automatic reset_and_sweep(input string nm);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".rst_ready"}, 32'(req_ready), 32'd0);
    chk({nm, ".rst_resp"}, 32'(resp_valid), 32'd0);
    chk({nm, ".rst_hit"}, 32'(resp_hit), 32'd0);
    chk({nm, ".rst_mem_req"}, 32'(mem_req), 32'd0);
    chk({nm, ".rst_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({nm, ".rst_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, ".rst_ts_idx"}, 32'(ts_index), 32'd0);
    chk({nm, ".rst_ts_wr_n"}, 32'(ts_wr_n), 32'd0);
    rst = 1'b0;
    sweep_check(nm);
  endtask

  typedef struct {
    logic        pl;
    logic [4:0]  pl_idx;
    logic [7:0]  pl_data;
    logic        wr;
    logic [15:0] addr;
    int          dly;
    logic        e_hit;
    int          e_lat;
    logic [15:0] e_wb;
    logic [15:0] e_fill;
    logic [7:0]  e_entry;
  } vec_t;

  vec_t tbl [7];

  initial begin
    obs_t o, p;
    logic [15:0] a;
    logic        w;
    int          d;
    logic        found;

    tbl[0] = '{1'b1, 5'd3, 8'hC5, 1'b0, 16'h1460, 0, 1'b1, 2, 16'h0000, 16'h0000, 8'hC5};
    tbl[1] = '{1'b1, 5'd3, 8'h85, 1'b1, 16'h1460, 0, 1'b1, 3, 16'h0000, 16'h0000, 8'hC5};
    tbl[2] = '{1'b1, 5'd3, 8'hC5, 1'b0, 16'h2860, 2, 1'b0, 9, 16'h1460, 16'h2860, 8'h8A};
    tbl[3] = '{1'b0, 5'd0, 8'h00, 1'b1, 16'h2860, 0, 1'b1, 3, 16'h0000, 16'h0000, 8'hCA};
    tbl[4] = '{1'b0, 5'd0, 8'h00, 1'b1, 16'h2860, 1, 1'b1, 2, 16'h0000, 16'h0000, 8'hCA};
    tbl[5] = '{1'b1, 5'd7, 8'h00, 1'b0, 16'h00E0, 0, 1'b0, 4, 16'h0000, 16'h00E0, 8'h80};
    tbl[6] = '{1'b1, 5'd9, 8'h83, 1'b1, 16'h1120, 3, 1'b0, 7, 16'h0000, 16'h1120, 8'hC4};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0;
    mem_ack = 1'b0; pl_en = 1'b0; pl_idx = 5'd0; pl_data = 8'h0;
    m_hit = 16'h0; m_miss = 16'h0;
    repeat (2) @(negedge clk);

    reset_and_sweep("init");

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pl) preload(tbl[i].pl_idx, tbl[i].pl_data);
      p = predict(tbl[i].wr, tbl[i].addr, tbl[i].dly);
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].dly, o);
      chk($sformatf("vec%0d.hit", i), 32'(o.hit), 32'(tbl[i].e_hit));
      chk($sformatf("vec%0d.latency", i), 32'(o.lat), 32'(tbl[i].e_lat));
      chk($sformatf("vec%0d.wb_addr", i), 32'(o.wb_a), 32'(tbl[i].e_wb));
      chk($sformatf("vec%0d.fill_addr", i), 32'(o.fill_a), 32'(tbl[i].e_fill));
      chk($sformatf("vec%0d.entry", i), 32'(ts_mem[tbl[i].addr[9:5]]), 32'(tbl[i].e_entry));
      cmp($sformatf("vec%0d", i), o, p, tbl[i].addr[9:5]);
    end

    for (int i = 0; i < 40; i++) begin
      a = {4'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(0, 3)), 5'($urandom)};
      a = {a[15:12] == 4'd0 ? 6'd0 : 6'(a[15:12]), a[9:0]};
      w = 1'($urandom);
      d = $urandom_range(0, 3);
      p = predict(w, a, d);
      run_txn(w, a, d, o);
      cmp($sformatf("rnd%0d", i), o, p, a[9:5]);
    end

    // Reset while a fill is outstanding, then reset again mid-sweep.
    preload(5'd3, 8'h00);
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h1460;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req && !mem_wr) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort.fill_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.mem_req_drop", 32'(mem_req), 32'd0);
    chk("abort.no_resp", 32'(resp_valid), 32'd0);
    chk("abort.ts_idx", 32'(ts_index), 32'd0);
    chk("abort.ts_wr_n", 32'(ts_wr_n), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("partial.sweep_idx", 32'(ts_index), 32'(i));
      chk("partial.no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    reset_and_sweep("restart");

    // Three hits and two misses on a freshly cleared tag store.
    for (int i = 0; i < 5; i++) begin
      a = (i < 3) ? 16'h0020 : 16'h0420;
      p = predict(1'b0, a, 1);
      run_txn(1'b0, a, 1, o);
      cmp($sformatf("cnt%0d", i), o, p, a[9:5]);
    end
    chk("cnt.model_hits", 32'(m_hit), 32'd3);
    chk("cnt.model_misses", 32'(m_miss), 32'd2);
`ifdef DC_PERF_CNT_EN
    chk("cnt.hit_cnt", 32'(hit_cnt), 32'd3);
    chk("cnt.miss_cnt", 32'(miss_cnt), 32'd2);
    force dut.r_hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
    m_hit = 16'hFFFF;
    p = predict(1'b0, 16'h0420, 0);
    run_txn(1'b0, 16'h0420, 0, o);
    cmp("sat", o, p, 5'd1);
    chk("sat.hit_cnt", 32'(hit_cnt), 32'hFFFF);
    chk("sat.miss_cnt", 32'(miss_cnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
